// File: rtl/iq_frame_sched.sv
// iq_frame_sched: ping-pong I/Q frame assembler and credit-limited scheduler feeding
// the modulation classifier core. Define IQ_FRAME_SCHED_STATS_EN to enable stat_* counters.
module iq_frame_sched #(
    parameter int BW      = 16,
    parameter int L2_IMG  = 10,
    parameter int CH_OUT  = 24,
    parameter int BW_OUT  = 16,
    parameter int CREDITS = 2,
    parameter int FID_BW  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_vld,
    output logic                           s_rdy,
    input  logic [1:0][BW-1:0]             s_data,
    output logic                           net_vld_in,
    output logic [3:0][BW-1:0]             net_data_in,
    input  logic                           net_vld_out,
    input  logic [CH_OUT-1:0][BW_OUT-1:0]  net_data_out,
    output logic                           m_vld,
    input  logic                           m_rdy,
    output logic [CH_OUT-1:0][BW_OUT-1:0]  m_data,
    output logic [FID_BW-1:0]              m_fid,
    output logic                           err,
    output logic [31:0]                    stat_frames,
    output logic [31:0]                    stat_stall
);
    localparam int AW    = L2_IMG - 1;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = $clog2(CREDITS + 1);
    localparam int PW    = (CREDITS > 1) ? $clog2(CREDITS) : 1;

    localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [PW-1:0] PTR_LAST = PW'(CREDITS - 1);

    typedef enum logic {IDLE, ISSUE} rd_state_t;

    logic [3:0][BW-1:0]            bank_mem [0:2*DEPTH-1];
    logic [1:0][BW-1:0]            held;
    logic                          odd;
    logic                          wr_bank;
    logic [AW-1:0]                 wr_addr;
    logic [1:0]                    bank_full;
    logic [1:0]                    full_nxt;
    logic                          wr_bank_nxt;

    rd_state_t                     state;
    logic                          rd_bank;
    logic [AW-1:0]                 rd_addr;
    logic [CW-1:0]                 credits;
    logic [CW-1:0]                 outstanding;

    logic [CH_OUT-1:0][BW_OUT-1:0] fifo_mem [0:CREDITS-1];
    logic [PW-1:0]                 fifo_wr;
    logic [PW-1:0]                 fifo_rd;
    logic [CW-1:0]                 fifo_cnt;

    logic wr_fire;
    logic wr_word;
    logic wr_done;
    logic rd_done;
    logic issue_start;
    logic push;
    logic pop;

    assign wr_fire     = s_vld && s_rdy;
    assign wr_word     = wr_fire && odd;
    assign wr_done     = wr_word && (wr_addr == LAST);
    assign rd_done     = (state == ISSUE) && (rd_addr == LAST);
    assign issue_start = (state == IDLE) && bank_full[rd_bank] && (credits != '0);
    assign pop         = m_vld && m_rdy;
    assign push        = net_vld_out && (outstanding != '0);

    // Writer moves to the other bank as soon as its own is full and the other is free;
    // s_rdy is derived from this next state so no sample can land in a full bank.
    always_comb begin
        full_nxt = bank_full;
        if (wr_done) full_nxt[wr_bank] = 1'b1;
        if (rd_done) full_nxt[rd_bank] = 1'b0;
        wr_bank_nxt = wr_bank;
        if (full_nxt[wr_bank] && !full_nxt[!wr_bank]) wr_bank_nxt = !wr_bank;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_rdy     <= 1'b0;
            odd       <= 1'b0;
            held      <= '0;
            wr_addr   <= '0;
            wr_bank   <= 1'b0;
            bank_full <= '0;
        end else begin
            bank_full <= full_nxt;
            wr_bank   <= wr_bank_nxt;
            s_rdy     <= !full_nxt[wr_bank_nxt];
            if (wr_fire) begin
                odd <= !odd;
                if (!odd) held <= s_data;
            end
            if (wr_word) wr_addr <= wr_addr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_word) bank_mem[{wr_bank, wr_addr}] <= {held, s_data};
    end

    // Banks are filled alternately, so the reader simply alternates too.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rd_bank     <= 1'b0;
            rd_addr     <= '0;
            net_vld_in  <= 1'b0;
            net_data_in <= '0;
        end else begin
            net_vld_in <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue_start) state <= ISSUE;
                end
                ISSUE: begin
                    net_vld_in  <= 1'b1;
                    net_data_in <= bank_mem[{rd_bank, rd_addr}];
                    rd_addr     <= rd_addr + 1'b1;
                    if (rd_done) begin
                        state   <= IDLE;
                        rd_bank <= !rd_bank;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // credits + outstanding + fifo_cnt == CREDITS at all times, so an accepted push always has room.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits     <= CRED_MAX;
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            credits     <= credits + CW'(pop) - CW'(issue_start);
            outstanding <= outstanding + CW'(issue_start) - CW'(push);
            if (net_vld_out && (outstanding == '0)) err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_wr  <= '0;
            fifo_rd  <= '0;
            fifo_cnt <= '0;
            m_fid    <= '0;
        end else begin
            if (push) fifo_wr <= (fifo_wr == PTR_LAST) ? '0 : fifo_wr + 1'b1;
            if (pop) begin
                fifo_rd <= (fifo_rd == PTR_LAST) ? '0 : fifo_rd + 1'b1;
                m_fid   <= m_fid + 1'b1;
            end
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[fifo_wr] <= net_data_out;
    end

    assign m_vld  = (fifo_cnt != '0);
    assign m_data = m_vld ? fifo_mem[fifo_rd] : '0;

`ifdef IQ_FRAME_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_frames <= '0;
            stat_stall  <= '0;
        end else begin
            if (issue_start && (stat_frames != '1)) stat_frames <= stat_frames + 1'b1;
            if (s_vld && !s_rdy && (stat_stall != '1)) stat_stall <= stat_stall + 1'b1;
        end
    end
`else
    assign stat_frames = '0;
    assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_iq_frame_sched.sv
// Self-checking bench for iq_frame_sched: scenario table plus hand sequences, all checked
// against a sample-queue reference model and a simple core model.
module tb_iq_frame_sched;
    localparam int BW      = 16;
    localparam int L2_IMG  = 10;
    localparam int CH_OUT  = 24;
    localparam int BW_OUT  = 16;
    localparam int CREDITS = 2;
    localparam int FID_BW  = 4;
    localparam int FRAME   = 1 << L2_IMG;
    localparam int WORDS   = FRAME / 2;
    localparam int CMPW    = CH_OUT * BW_OUT;

    typedef logic [1:0][BW-1:0]            samp_t;
    typedef logic [CH_OUT-1:0][BW_OUT-1:0] score_t;

    typedef struct {
        int duty;
        int rdy_duty;
        int nframes;
        int base;
        int exp_issued;
        int exp_fid;
        int exp_lat;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  s_vld;
    logic                  s_rdy;
    samp_t                 s_data;
    logic                  net_vld_in;
    logic [3:0][BW-1:0]    net_data_in;
    logic                  net_vld_out;
    score_t                net_data_out;
    logic                  m_vld;
    logic                  m_rdy;
    score_t                m_data;
    logic [FID_BW-1:0]     m_fid;
    logic                  err;
    logic [31:0]           stat_frames;
    logic [31:0]           stat_stall;

    iq_frame_sched #(
        .BW(BW), .L2_IMG(L2_IMG), .CH_OUT(CH_OUT), .BW_OUT(BW_OUT),
        .CREDITS(CREDITS), .FID_BW(FID_BW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_vld(s_vld), .s_rdy(s_rdy), .s_data(s_data),
        .net_vld_in(net_vld_in), .net_data_in(net_data_in),
        .net_vld_out(net_vld_out), .net_data_out(net_data_out),
        .m_vld(m_vld), .m_rdy(m_rdy), .m_data(m_data), .m_fid(m_fid),
        .err(err), .stat_frames(stat_frames), .stat_stall(stat_stall)
    );

    always #5 clk = ~clk;

    int    n_checks;
    int    n_fail;
    samp_t in_q[$];
    int    samp_n, samples_left, accepted;
    int    duty, rdy_duty;
    int    run_len, issued, frames_done, results_sent, pops, stalls;
    int    cyc, last_acc_cyc, first_vld_cyc;
    bit    spur;
    logic [4*BW-1:0] first_word, last_word;
    vec_t  vecs[5];

    function automatic samp_t sample(int n);
        samp_t s;
        s[1] = BW'(n);
        s[0] = BW'(-n);
        return s;
    endfunction

    function automatic score_t scores(int k);
        score_t s;
        for (int j = 0; j < CH_OUT; j++) s[j] = BW_OUT'((k & 255) * 256 + j);
        return s;
    endfunction

    task automatic check_output(string name, logic [CMPW-1:0] act, logic [CMPW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: every accepted sample queues up; each issued word must be the next two.
    task automatic observe();
        samp_t a, b;
        cyc++;
        if (!rst) return;
        if (s_vld && !s_rdy) stalls++;
        if (s_vld && s_rdy) begin
            in_q.push_back(s_data);
            accepted++;
            samp_n++;
            samples_left--;
            if (accepted % FRAME == 0) last_acc_cyc = cyc;
        end
        if (net_vld_in) begin
            if (run_len == 0) begin
                issued++;
                first_vld_cyc = cyc;
                first_word = net_data_in;
            end
            if (in_q.size() < 2) begin
                check_output("net_underflow", CMPW'(in_q.size()), CMPW'(2));
            end else begin
                a = in_q.pop_front();
                b = in_q.pop_front();
                check_output("net_data", CMPW'(net_data_in), CMPW'({a, b}));
            end
            run_len++;
            if (run_len == WORDS) begin
                frames_done++;
                last_word = net_data_in;
            end
        end else if (run_len != 0) begin
            check_output("burst_len", CMPW'(run_len), CMPW'(WORDS));
            run_len = 0;
        end
        if (m_vld && m_rdy) begin
            check_output("m_data", m_data, scores(pops));
            check_output("m_fid", CMPW'(m_fid), CMPW'(pops % (1 << FID_BW)));
            pops++;
        end
    endtask

    task automatic drive();
        if (samples_left > 0 && $urandom_range(99) < duty) begin
            s_vld  = 1'b1;
            s_data = sample(samp_n);
        end else begin
            s_vld  = 1'b0;
            s_data = '0;
        end
        if (spur) begin
            net_vld_out  = 1'b1;
            net_data_out = scores(200);
            spur = 1'b0;
        end else if (frames_done > results_sent) begin
            net_vld_out  = 1'b1;
            net_data_out = scores(results_sent);
            results_sent++;
        end else begin
            net_vld_out  = 1'b0;
            net_data_out = '0;
        end
        m_rdy = ($urandom_range(99) < rdy_duty);
    endtask

    task automatic cycle_step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic clear_model(int base);
        in_q.delete();
        samp_n = base;
        samples_left = 0; accepted = 0;
        run_len = 0; issued = 0; frames_done = 0; results_sent = 0;
        pops = 0; stalls = 0; spur = 1'b0;
        first_word = '0; last_word = '0;
    endtask

    task automatic do_reset(int base);
        rst = 1'b0;
        s_vld = 1'b0; s_data = '0;
        net_vld_out = 1'b0; net_data_out = '0; m_rdy = 1'b0;
        clear_model(base);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic run_frames(int nframes, int budget);
        int target;
        target = pops + nframes;
        samples_left = nframes * FRAME;
        for (int c = 0; c < budget && (samples_left > 0 || pops < target); c++) cycle_step();
        check_output("run_timeout", CMPW'(samples_left == 0 && pops >= target), CMPW'(1));
        repeat (4) cycle_step();
    endtask

    task automatic check_stats();
`ifdef IQ_FRAME_SCHED_STATS_EN
        check_output("stat_frames", CMPW'(stat_frames), CMPW'(issued));
        check_output("stat_stall", CMPW'(stat_stall), CMPW'(stalls));
`else
        check_output("stat_frames", CMPW'(stat_frames), CMPW'(0));
        check_output("stat_stall", CMPW'(stat_stall), CMPW'(0));
`endif
    endtask

    task automatic check_all_zero(string tag);
        check_output({tag, "_s_rdy"}, CMPW'(s_rdy), CMPW'(0));
        check_output({tag, "_net_vld_in"}, CMPW'(net_vld_in), CMPW'(0));
        check_output({tag, "_net_data_in"}, CMPW'(net_data_in), CMPW'(0));
        check_output({tag, "_m_vld"}, CMPW'(m_vld), CMPW'(0));
        check_output({tag, "_m_data"}, m_data, CMPW'(0));
        check_output({tag, "_m_fid"}, CMPW'(m_fid), CMPW'(0));
        check_output({tag, "_err"}, CMPW'(err), CMPW'(0));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        duty     = 100;
        rdy_duty = 100;
        vecs[0] = '{duty: 100, rdy_duty: 100, nframes: 1,  base: 0,     exp_issued: 1,  exp_fid: 1, exp_lat: 3};
        vecs[1] = '{duty: 50,  rdy_duty: 100, nframes: 3,  base: 2000,  exp_issued: 3,  exp_fid: 3, exp_lat: -1};
        vecs[2] = '{duty: 100, rdy_duty: 30,  nframes: 4,  base: 7000,  exp_issued: 4,  exp_fid: 4, exp_lat: -1};
        vecs[3] = '{duty: 70,  rdy_duty: 60,  nframes: 5,  base: 20000, exp_issued: 5,  exp_fid: 5, exp_lat: -1};
        vecs[4] = '{duty: 100, rdy_duty: 100, nframes: 17, base: 100,   exp_issued: 17, exp_fid: 1, exp_lat: -1};

        rst = 1'b0;
        s_vld = 1'b0; s_data = '0;
        net_vld_out = 1'b0; net_data_out = '0; m_rdy = 1'b0;
        clear_model(0);
        #3;
        check_all_zero("reset");
        do_reset(0);
        check_output("s_rdy_after_release", CMPW'(s_rdy), CMPW'(0));
        cycle_step();
        check_output("s_rdy_rise", CMPW'(s_rdy), CMPW'(1));

        for (int i = 0; i < 5; i++) begin
            do_reset(vecs[i].base);
            duty     = vecs[i].duty;
            rdy_duty = vecs[i].rdy_duty;
            run_frames(vecs[i].nframes, vecs[i].nframes * FRAME * 4 + 3000);
            check_output("vec_issued", CMPW'(issued), CMPW'(vecs[i].exp_issued));
            check_output("vec_fid", CMPW'(m_fid), CMPW'(vecs[i].exp_fid));
            check_output("vec_err", CMPW'(err), CMPW'(0));
            check_output("vec_m_vld", CMPW'(m_vld), CMPW'(0));
            check_output("vec_s_rdy", CMPW'(s_rdy), CMPW'(1));
            check_stats();
            if (vecs[i].exp_lat >= 0)
                check_output("issue_latency", CMPW'(first_vld_cyc - last_acc_cyc), CMPW'(vecs[i].exp_lat));
            if (i == 0) begin
                check_output("first_word", CMPW'(first_word), CMPW'(64'h0000_0000_0001_ffff));
                check_output("last_word", CMPW'(last_word), CMPW'(64'h03fe_fc02_03ff_fc01));
            end
        end

        // Credit stall: two frames go out, two more park in the banks until results drain.
        do_reset(0);
        duty = 100;
        rdy_duty = 0;
        samples_left = 4 * FRAME;
        for (int c = 0; c < 8000 && samples_left > 0; c++) cycle_step();
        repeat (20) cycle_step();
        check_output("stall_fill", CMPW'(samples_left), CMPW'(0));
        check_output("stall_issued", CMPW'(issued), CMPW'(2));
        check_output("stall_s_rdy", CMPW'(s_rdy), CMPW'(0));
        check_output("stall_m_vld", CMPW'(m_vld), CMPW'(1));
        check_output("stall_pops", CMPW'(pops), CMPW'(0));
        rdy_duty = 100;
        for (int c = 0; c < 4000 && pops < 4; c++) cycle_step();
        repeat (4) cycle_step();
        check_output("stall_issued_final", CMPW'(issued), CMPW'(4));
        check_output("stall_pops_final", CMPW'(pops), CMPW'(4));
        check_output("stall_fid_final", CMPW'(m_fid), CMPW'(4));
        check_stats();

        // Reset in the middle of a frame discards the partial data.
        do_reset(0);
        samples_left = FRAME;
        for (int c = 0; c < 1000 && accepted < 300; c++) cycle_step();
        rst = 1'b0;
        #1;
        check_all_zero("midreset");
        do_reset(5000);
        run_frames(1, FRAME * 4);
        check_output("midreset_pops", CMPW'(pops), CMPW'(1));
        check_output("midreset_first", CMPW'(first_word), CMPW'(64'h1388_ec78_1389_ec77));

        // Spurious core result with nothing in flight.
        do_reset(0);
        spur = 1'b1;
        cycle_step();
        cycle_step();
        cycle_step();
        check_output("spur_err", CMPW'(err), CMPW'(1));
        check_output("spur_m_vld", CMPW'(m_vld), CMPW'(0));
        repeat (10) cycle_step();
        check_output("spur_err_sticky", CMPW'(err), CMPW'(1));
        check_output("spur_m_vld_late", CMPW'(m_vld), CMPW'(0));
        do_reset(0);
        check_output("spur_err_cleared", CMPW'(err), CMPW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
